instr_fetch: RTL and testbench

Instruction fetch stage for the little computer: owns the program counter, requests 16-bit instruction words from instruction memory over a req/ack handshake, and presents the held word on `instr` to the control decoder directly downstream. It stops fetching permanently when control decodes `OP_HALT`. It redirects the PC on a jump/branch request. Only reset leaves the halted state.

---
 rtl/instr_fetch.sv | 176 +++++++++++++++++
 tb/tb_instr_fetch.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches 16-bit words over a req/ack
// handshake, holds the word for the decoder, stops for good on HALT and
// follows jump/branch redirects.
// Optional build macro: FETCH_TIMEOUT_EN adds a memory-ack watchdog that
// moves the stage into a terminal FAULT state.
module instr_fetch #(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned RESET_PC       = 0,
  parameter int unsigned TIMEOUT_CYCLES = 15,
  localparam int unsigned InstrWidth    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_ack,
  input  logic [InstrWidth-1:0] mem_rdata,
  output logic [InstrWidth-1:0] instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  halted,
  input  logic                  redirect_valid,
  input  logic [ADDR_W-1:0]     redirect_pc,
  output logic [ADDR_W-1:0]     pc,
  output logic                  fault
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_HOLD   = 3'd2,
    S_HALTED = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t                  r_state;
  logic [ADDR_W-1:0]       r_pc;
  logic [InstrWidth-1:0]   r_instr;
  logic                    r_instr_valid;
  logic                    r_mem_req;
  logic                    r_redir_pend;
  logic [ADDR_W-1:0]       r_redir_pc;

  state_t                  w_state_d;
  logic [ADDR_W-1:0]       w_pc_d;
  logic [InstrWidth-1:0]   w_instr_d;
  logic                    w_instr_valid_d;
  logic                    w_mem_req_d;
  logic                    w_redir_pend_d;
  logic [ADDR_W-1:0]       w_redir_pc_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned ToW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [ToW-1:0]          r_to_cnt;
  logic                    r_fault;
  logic [ToW-1:0]          w_to_cnt_d;
  logic                    w_fault_d;

  assign fault = r_fault;
`else
  // Timeout depth only matters when the watchdog is built in.
  logic w_unused_cfg;
  assign w_unused_cfg = ^TIMEOUT_CYCLES;
  assign fault        = 1'b0;
`endif

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;

  // Next-state and next-output decode for the fetch FSM.
  always_comb begin
    w_state_d       = r_state;
    w_pc_d          = r_pc;
    w_instr_d       = r_instr;
    w_instr_valid_d = r_instr_valid;
    w_mem_req_d     = r_mem_req;
    w_redir_pend_d  = r_redir_pend;
    w_redir_pc_d    = r_redir_pc;
`ifdef FETCH_TIMEOUT_EN
    w_to_cnt_d      = r_to_cnt;
    w_fault_d       = r_fault;
`endif
    case (r_state)
      S_IDLE: begin
        w_state_d   = S_WAIT;
        w_mem_req_d = 1'b1;
`ifdef FETCH_TIMEOUT_EN
        w_to_cnt_d  = '0;
`endif
      end
      S_WAIT: begin
        if (mem_ack) begin
          if (r_redir_pend || redirect_valid) begin
            // Stale word: drop it and refetch at the newest redirect target.
            w_pc_d         = redirect_valid ? redirect_pc : r_redir_pc;
            w_redir_pend_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
            w_to_cnt_d     = '0;
`endif
          end else begin
            w_instr_d       = mem_rdata;
            w_instr_valid_d = 1'b1;
            w_mem_req_d     = 1'b0;
            w_state_d       = S_HOLD;
          end
        end else begin
          if (redirect_valid) begin
            w_redir_pend_d = 1'b1;
            w_redir_pc_d   = redirect_pc;
          end
`ifdef FETCH_TIMEOUT_EN
          if (r_to_cnt == ToW'(TIMEOUT_CYCLES - 1)) begin
            w_state_d       = S_FAULT;
            w_fault_d       = 1'b1;
            w_mem_req_d     = 1'b0;
            w_instr_valid_d = 1'b0;
            w_redir_pend_d  = 1'b0;
          end else begin
            w_to_cnt_d = r_to_cnt + ToW'(1);
          end
`endif
        end
      end
      S_HOLD: begin
        if (halted) begin
          w_state_d = S_HALTED;
        end else if (redirect_valid || instr_ready) begin
          w_pc_d          = redirect_valid ? redirect_pc : r_pc + ADDR_W'(1);
          w_instr_valid_d = 1'b0;
          w_mem_req_d     = 1'b1;
          w_state_d       = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
          w_to_cnt_d      = '0;
`endif
        end
      end
      default: begin
        // HALTED and FAULT are terminal until reset.
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= ADDR_W'(RESET_PC);
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_mem_req     <= 1'b0;
      r_redir_pend  <= 1'b0;
      r_redir_pc    <= '0;
`ifdef FETCH_TIMEOUT_EN
      r_to_cnt      <= '0;
      r_fault       <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_d;
      r_pc          <= w_pc_d;
      r_instr       <= w_instr_d;
      r_instr_valid <= w_instr_valid_d;
      r_mem_req     <= w_mem_req_d;
      r_redir_pend  <= w_redir_pend_d;
      r_redir_pc    <= w_redir_pc_d;
`ifdef FETCH_TIMEOUT_EN
      r_to_cnt      <= w_to_cnt_d;
      r_fault       <= w_fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: table-driven fetch/redirect vectors,
// then hand-written sequences for WAIT redirect, PC wrap, reset, HALT and
// the optional fetch timeout (FETCH_TIMEOUT_EN).
module tb_instr_fetch;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [15:0]   mem_rdata;
  logic [15:0]   instr;
  logic          instr_valid;
  logic          instr_ready;
  logic          halted;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] pc;
  logic          fault;

  // Memory model and control-decoder stand-in.
  logic [15:0] mem [0:1023];
  int          mem_lat;
  logic        mem_on;
  logic        ctl_on;
  int          wcnt;

  int n_checks;
  int n_pass;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(AW), .RESET_PC(0), .TIMEOUT_CYCLES(15)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .halted         (halted),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .fault          (fault)
  );

  // Control decodes OP_HALT (opcode 4'hF) from the held instruction.
  assign halted = ctl_on & instr_valid & (instr[15:12] == 4'hF);

  // Memory responder: acks after mem_lat idle request cycles.
  always @(negedge clk) begin
    if (mem_req && mem_on) begin
      if (wcnt >= mem_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        wcnt      = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt    = wcnt + 1;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
  end

  typedef struct {
    logic          ready;
    logic          redir;
    logic [AW-1:0] rpc;
    logic          exp_req;
    logic          exp_valid;
    logic [AW-1:0] exp_pc;
    logic [15:0]   exp_instr;
  } vec_t;

  vec_t vecs [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] snap();
    return {26'd0, mem_req, instr_valid, pc, mem_addr, instr};
  endfunction

  function automatic logic [63:0] exp_snap(input logic req, input logic vld,
                                           input logic [AW-1:0] p, input logic [15:0] ins);
    return {26'd0, req, vld, p, p, ins};
  endfunction

  task automatic advance_to_hold(input logic [AW-1:0] tgt, input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (instr_valid && pc == tgt) begin
        found = 1'b1;
        break;
      end
      instr_ready = 1'b1;
      step();
    end
    instr_ready = 1'b0;
    check(name, 64'(found), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic seen_valid;
    logic reached;

    n_checks       = 0;
    n_pass         = 0;
    rst_n          = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_lat        = 0;
    mem_on         = 1'b1;
    ctl_on         = 1'b0;
    mem_ack        = 1'b0;
    mem_rdata      = '0;
    wcnt           = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h1000 | 16'(i);

    vecs[0]  = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 10'h000, 16'h1000};
    vecs[2]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h000, 16'h1000};
    vecs[3]  = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 10'h001, 16'h1000};
    vecs[4]  = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 10'h001, 16'h1001};
    vecs[5]  = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 10'h002, 16'h1001};
    vecs[6]  = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 10'h002, 16'h1002};
    vecs[7]  = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 10'h003, 16'h1002};
    vecs[8]  = '{1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 10'h003, 16'h1003};
    vecs[9]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h003, 16'h1003};
    vecs[10] = '{1'b0, 1'b1, 10'h005, 1'b1, 1'b0, 10'h005, 16'h1003};
    vecs[11] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h005, 16'h1005};
    vecs[12] = '{1'b1, 1'b1, 10'h100, 1'b1, 1'b0, 10'h100, 16'h1005};
    vecs[13] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h100, 16'h1100};

    // Reset values.
    repeat (3) step();
    check("reset_state", snap(), exp_snap(1'b0, 1'b0, 10'h000, 16'h0000));
    check("reset_fault", 64'(fault), 64'd0);
    rst_n = 1'b1;

    // Zero-wait fetch stream, hold, redirect and redirect+ready.
    for (int i = 0; i < 14; i++) begin
      instr_ready    = vecs[i].ready;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      step();
      check($sformatf("vec%0d", i), snap(),
            exp_snap(vecs[i].exp_req, vecs[i].exp_valid, vecs[i].exp_pc, vecs[i].exp_instr));
    end
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;

    // Redirect while waiting: word for address 7 must never be presented.
    mem_lat        = 3;
    redirect_valid = 1'b1;
    redirect_pc    = 10'h007;
    step();
    redirect_valid = 1'b0;
    check("redir_to_7", snap(), exp_snap(1'b1, 1'b0, 10'h007, 16'h1100));
    redirect_valid = 1'b1;
    redirect_pc    = 10'h040;
    step();
    redirect_valid = 1'b0;
    check("pend_keeps_addr", snap(), exp_snap(1'b1, 1'b0, 10'h007, 16'h1100));
    seen_valid = 1'b0;
    reached    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pc == 10'h040) begin
        reached = 1'b1;
        break;
      end
      if (instr_valid) seen_valid = 1'b1;
      step();
    end
    check("redir_discard", 64'({reached, seen_valid, mem_req}), 64'(3'b101));
    mem_lat = 0;
    advance_to_hold(10'h040, "hold_0x40");
    check("instr_0x40", 64'(instr), 64'h1040);

    // PC wrap from all-ones.
    redirect_valid = 1'b1;
    redirect_pc    = 10'h3FF;
    step();
    redirect_valid = 1'b0;
    advance_to_hold(10'h3FF, "hold_0x3ff");
    check("instr_0x3ff", 64'(instr), 64'h13FF);
    mem_lat     = 5;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    check("pc_wrap", snap(), exp_snap(1'b1, 1'b0, 10'h000, 16'h13FF));

    // Reset in the middle of WAIT, then first request timing.
    rst_n = 1'b0;
    step();
    check("reset_midwait", snap(), exp_snap(1'b0, 1'b0, 10'h000, 16'h0000));
    rst_n   = 1'b1;
    mem_lat = 0;
    step();
    check("first_req", snap(), exp_snap(1'b1, 1'b0, 10'h000, 16'h0000));

    // HALT at word 2 is terminal; ready and redirect are ignored.
    mem[2] = 16'hF000;
    ctl_on = 1'b1;
    advance_to_hold(10'h002, "hold_halt");
    for (int i = 0; i < 20; i++) begin
      instr_ready    = 1'b1;
      redirect_valid = 1'(i % 2);
      redirect_pc    = 10'h055;
      step();
      check($sformatf("halted_%0d", i), snap(), exp_snap(1'b0, 1'b1, 10'h002, 16'hF000));
    end
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;

    // Memory never acks.
    ctl_on = 1'b0;
    rst_n  = 1'b0;
    step();
    step();
    mem_on = 1'b0;
    rst_n  = 1'b1;
`ifdef FETCH_TIMEOUT_EN
    repeat (15) step();
    check("pre_timeout", 64'({fault, mem_req}), 64'(2'b01));
    step();
    check("timeout_fault", 64'({fault, mem_req, instr_valid}), 64'(3'b100));
    rst_n = 1'b0;
    step();
    check("fault_reset", 64'({fault, mem_req, pc}), 64'd0);
    rst_n = 1'b1;
`else
    repeat (20) step();
    check("no_timeout", 64'({fault, mem_req}), 64'(2'b01));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
